trap_ctrl: RTL and testbench
============================

# trap_ctrl

Machine-mode trap sequencer between the core-local interrupt lines (timer and software IRQ from the CLINT, plus one external line) and the pipeline/CSR file. It registers the raw IRQ levels into `mip` and arbitrates interrupts against synchronous exceptions and `mret`. For each trap it runs a fixed two-cycle entry sequence: a CSR save pulse, then a PC redirect pulse. It stalls the pipeline while the sequence runs.

## Interface
- `DATA_WIDTH`, 32, width of PC/CSR datapaths
- `clk_i` in 1: single clock, all state updates on rising edge
- `rst_i` in 1: synchronous, active-high reset
- `timer_irq_i` in 1: level, machine timer interrupt (CLINT)
- `software_irq_i` in 1: level, machine software interrupt (CLINT)
- `external_irq_i` in 1: level, machine external interrupt
- `mstatus_mie_i` in 1: global interrupt enable from CSR file
- `mie_i` in 32: interrupt enable CSR; bits 3/7/11 used
- `mtvec_i` in 32: trap vector; [1:0]=1 vectored, else direct
- `mepc_i` in 32: current mepc, `mret` target
- `inst_valid_i` in 1: execute stage holds a valid instruction
- `inst_pc_i` in 32: PC of that instruction
- `exc_valid_i` in 1: synchronous exception on that instruction
- `exc_cause_i` in 4: exception code
- `exc_tval_i` in 32: exception mtval
- `mret_i` in 1: that instruction is `mret`
- `mip_o` out 32: registered pending bits (3=MSIP, 7=MTIP, 11=MEIP, others 0)
- `stall_o` out 1: hold fetch/decode/execute
- `csr_we_o` out 1: one-cycle pulse; CSR file writes mepc/mcause/mtval and sets MPIE←MIE, MIE←0
- `mepc_o`, `mcause_o`, `mtval_o` out 32 each: values written on `csr_we_o`
- `mret_o` out 1: one-cycle pulse; CSR file sets MIE←MPIE, MPIE←1
- `redirect_o` out 1: one-cycle pulse; flush pipeline and fetch from `redirect_pc_o`
- `redirect_pc_o` out 32: redirect target

## Operation
- `mip_o` is a plain register of the three IRQ levels, updated every cycle and not gated by enables.
- `pend = mip_o & mie_i & {32{mstatus_mie_i}}`.
- Decision is evaluated only in IDLE with `inst_valid_i=1`. Priority: exception > MEI(11) > MSI(3) > MTI(7) > `mret`.
- Exception:
  - mcause = {28'b0, exc_cause_i}
  - mepc = inst_pc_i, mtval = exc_tval_i
  - target = mtvec_i & ~3
- Interrupt code c:
  - mcause = {1'b1, 27'b0, c[3:0]}
  - mepc = inst_pc_i (instruction not executed), mtval = 0
  - target = (mtvec_i & ~3) + 4*c if mtvec_i[1:0]==1, else mtvec_i & ~3
- `mret` with nothing higher: target = mepc_i.
- mepc/mcause/mtval/target are latched into registers at the decision edge and held stable until return to IDLE.
- FSM states:
  - IDLE
    - trap decision → SAVE
    - `mret` decision → MRET
    - otherwise stay
  - SAVE: `csr_we_o=1`, `stall_o=1` → JUMP
  - JUMP: `redirect_o=1`, `redirect_pc_o`=target, `stall_o=1` → IDLE
  - MRET: `mret_o=1`, `redirect_o=1`, `redirect_pc_o=mepc_i`, `stall_o=1` → IDLE
- In IDLE, `stall_o` is asserted combinationally in the decision cycle so the instruction is not retired.
- Pulse and interrupt rules:
  - `csr_we_o`, `mret_o` and `redirect_o` are each exactly one cycle per event and mutually exclusive with their own event's other states.
  - IRQ changes during SAVE/JUMP/MRET update `mip_o` but do not alter the latched event.
  - Interrupts re-evaluate only in IDLE. After SAVE, the CSR file has cleared MIE, so no back-to-back re-entry occurs.
- Reset: state←IDLE, and `mip_o`, latched registers and all pulse outputs ← 0. Reset mid-sequence aborts it with no further pulses.

## Timing
- IRQ rises at cycle N → `mip_o` bit set at N+1.
- Decision at N+1 (if enabled and `inst_valid_i`) → `csr_we_o` at N+2 → `redirect_o` at N+3 → IDLE at N+4.
- Exception at cycle E → `csr_we_o` at E+1, `redirect_o` at E+2.
- `mret` at cycle M → `mret_o` and `redirect_o` at M+1.
- `stall_o` is high from the decision cycle through the last pulse cycle inclusive.
- Reset values: `stall_o`, `csr_we_o`, `mret_o` and `redirect_o` are 0. `mip_o`, `mepc_o`, `mcause_o`, `mtval_o` and `redirect_pc_o` are 0.

## Test plan
- Timer IRQ with mie[7]=1, MIE=1, inst_pc=0x100, mtvec=0x8000_0000 → `mip_o`=0x80 next cycle; `csr_we_o` with mcause=0x8000_0007, mepc=0x100, mtval=0; then `redirect_pc_o`=0x8000_0000.
- All three IRQs together, mtvec=0x8000_0001 → mcause=0x8000_000B, `redirect_pc_o`=0x8000_002C; after MIE clears, no second entry.
- Exception cause 2, tval=0xDEAD, same cycle as pending MTI → mcause=2, mtval=0xDEAD, redirect 0x8000_0000; no interrupt entry that cycle.
- `mret` with mepc_i=0x204 and no pending IRQ → `mret_o` and `redirect_o` next cycle, `redirect_pc_o`=0x204. With MSI pending and enabled → interrupt with mepc=pc of `mret`, no `mret_o`.
- IRQ pending but `inst_valid_i`=0, or mie bit clear → `mip_o` set, no `stall_o`/`csr_we_o`, until valid and enabled.
- `rst_i` asserted in SAVE → next cycle IDLE, all outputs 0, no `redirect_o` pulse.

Source files
------------

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trap_ctrl
// Purpose  : Machine-mode trap sequencer. Registers the CLINT/external IRQ
//            levels into mip, arbitrates pending interrupts against
//            synchronous exceptions and mret, and drives a fixed entry
//            sequence (CSR save pulse, then PC redirect pulse) while
//            stalling the pipeline.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   timer_irq_i           machine timer interrupt level   (mip[7])
//   software_irq_i        machine software interrupt level (mip[3])
//   external_irq_i        machine external interrupt level (mip[11])
//   mstatus_mie_i         global interrupt enable
//   mie_i                 per-source interrupt enables
//   mtvec_i               trap vector base / mode
//   mepc_i                current mepc, target of mret
//   inst_valid_i          execute stage holds a valid instruction
//   inst_pc_i             PC of that instruction
//   exc_valid_i           synchronous exception on that instruction
//   exc_cause_i           exception code
//   exc_tval_i            exception mtval
//   mret_i                that instruction is mret
//   mip_o                 registered pending bits
//   stall_o               hold fetch/decode/execute
//   csr_we_o              pulse: write mepc/mcause/mtval, stack MIE
//   mepc_o/mcause_o/mtval_o values written on csr_we_o
//   mret_o                pulse: unstack MIE
//   redirect_o            pulse: flush and fetch from redirect_pc_o
//   redirect_pc_o         redirect target
// ============================================================================
module trap_ctrl #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  timer_irq_i,
   input  logic                  software_irq_i,
   input  logic                  external_irq_i,
   input  logic                  mstatus_mie_i,
   input  logic [DATA_WIDTH-1:0] mie_i,
   input  logic [DATA_WIDTH-1:0] mtvec_i,
   input  logic [DATA_WIDTH-1:0] mepc_i,
   input  logic                  inst_valid_i,
   input  logic [DATA_WIDTH-1:0] inst_pc_i,
   input  logic                  exc_valid_i,
   input  logic [3:0]            exc_cause_i,
   input  logic [DATA_WIDTH-1:0] exc_tval_i,
   input  logic                  mret_i,
   output logic [DATA_WIDTH-1:0] mip_o,
   output logic                  stall_o,
   output logic                  csr_we_o,
   output logic [DATA_WIDTH-1:0] mepc_o,
   output logic [DATA_WIDTH-1:0] mcause_o,
   output logic [DATA_WIDTH-1:0] mtval_o,
   output logic                  mret_o,
   output logic                  redirect_o,
   output logic [DATA_WIDTH-1:0] redirect_pc_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SAVE = 2'd1,
      S_JUMP = 2'd2,
      S_MRET = 2'd3
   } t_state;

   localparam logic [3:0] c_CODE_MSI = 4'd3;
   localparam logic [3:0] c_CODE_MTI = 4'd7;
   localparam logic [3:0] c_CODE_MEI = 4'd11;

   t_state                r_state;
   t_state                w_state_nxt;

   logic [DATA_WIDTH-1:0] r_mepc;
   logic [DATA_WIDTH-1:0] r_mcause;
   logic [DATA_WIDTH-1:0] r_mtval;
   logic [DATA_WIDTH-1:0] r_target;

   logic [DATA_WIDTH-1:0] w_pend;
   logic                  w_irq_any;
   logic [3:0]            w_irq_code;
   logic [DATA_WIDTH-1:0] w_base;
   logic [DATA_WIDTH-1:0] w_irq_target;
   logic                  w_take_exc;
   logic                  w_take_irq;
   logic                  w_take_mret;

   // ------------------------------------------------------------------------
   // Decision logic (only meaningful in IDLE)
   // ------------------------------------------------------------------------
   always_comb begin
      w_pend     = mip_o & mie_i & {DATA_WIDTH{mstatus_mie_i}};
      w_irq_any  = w_pend[11] | w_pend[3] | w_pend[7];
      // Fixed interrupt priority MEI > MSI > MTI
      if (w_pend[11]) begin
         w_irq_code = c_CODE_MEI;
      end else if (w_pend[3]) begin
         w_irq_code = c_CODE_MSI;
      end else begin
         w_irq_code = c_CODE_MTI;
      end
      w_base       = {mtvec_i[DATA_WIDTH-1:2], 2'b00};
      // Vectored mode places each interrupt at base + 4*code
      w_irq_target = (mtvec_i[1:0] == 2'b01)
                   ? w_base + DATA_WIDTH'({w_irq_code, 2'b00})
                   : w_base;
      w_take_exc   = inst_valid_i & exc_valid_i;
      w_take_irq   = inst_valid_i & ~exc_valid_i & w_irq_any;
      w_take_mret  = inst_valid_i & ~exc_valid_i & ~w_irq_any & mret_i;
   end

   // ------------------------------------------------------------------------
   // Next state and outputs
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt   = r_state;
      stall_o       = 1'b0;
      csr_we_o      = 1'b0;
      mret_o        = 1'b0;
      redirect_o    = 1'b0;
      redirect_pc_o = r_target;
      case (r_state)
         S_IDLE: begin
            if (w_take_exc || w_take_irq) begin
               // Stall in the decision cycle so the instruction does not retire
               stall_o     = 1'b1;
               w_state_nxt = S_SAVE;
            end else if (w_take_mret) begin
               stall_o     = 1'b1;
               w_state_nxt = S_MRET;
            end
         end
         S_SAVE: begin
            stall_o     = 1'b1;
            csr_we_o    = 1'b1;
            w_state_nxt = S_JUMP;
         end
         S_JUMP: begin
            stall_o     = 1'b1;
            redirect_o  = 1'b1;
            w_state_nxt = S_IDLE;
         end
         S_MRET: begin
            stall_o       = 1'b1;
            mret_o        = 1'b1;
            redirect_o    = 1'b1;
            redirect_pc_o = mepc_i;
            w_state_nxt   = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // State, pending bits and latched trap values
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= S_IDLE;
         mip_o    <= '0;
         r_mepc   <= '0;
         r_mcause <= '0;
         r_mtval  <= '0;
         r_target <= '0;
      end else begin
         r_state   <= w_state_nxt;
         mip_o     <= '0;
         mip_o[3]  <= software_irq_i;
         mip_o[7]  <= timer_irq_i;
         mip_o[11] <= external_irq_i;
         // Latch only on the decision edge; held through SAVE/JUMP
         if (r_state == S_IDLE) begin
            if (w_take_exc) begin
               r_mepc   <= inst_pc_i;
               r_mcause <= {{(DATA_WIDTH-4){1'b0}}, exc_cause_i};
               r_mtval  <= exc_tval_i;
               r_target <= w_base;
            end else if (w_take_irq) begin
               r_mepc   <= inst_pc_i;
               r_mcause <= {1'b1, {(DATA_WIDTH-5){1'b0}}, w_irq_code};
               r_mtval  <= '0;
               r_target <= w_irq_target;
            end
         end
      end
   end

   assign mepc_o   = r_mepc;
   assign mcause_o = r_mcause;
   assign mtval_o  = r_mtval;

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_trap_ctrl
// Purpose  : Directed scoreboard bench for trap_ctrl. Stimulus pushes the
//            expected pulse sequence; a negedge monitor pops and compares on
//            every csr_we/redirect/mret pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trap_ctrl;

   localparam int c_KIND_CSR  = 0;
   localparam int c_KIND_JMP  = 1;
   localparam int c_KIND_MRET = 2;

   typedef struct {
      int          kind;
      logic [31:0] a;   // mepc for CSR, target pc otherwise
      logic [31:0] b;   // mcause
      logic [31:0] c;   // mtval
   } t_exp;

   logic        clk = 1'b0;
   logic        rst;
   logic        timer_irq, software_irq, external_irq, mstatus_mie;
   logic [31:0] mie, mtvec, mepc_in, inst_pc, exc_tval;
   logic        inst_valid, exc_valid, mret;
   logic [3:0]  exc_cause;
   logic [31:0] mip, mepc_out, mcause_out, mtval_out, redirect_pc;
   logic        stall, csr_we, mret_out, redirect;

   t_exp        exp_q[$];
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   trap_ctrl #(.DATA_WIDTH(32)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .timer_irq_i    (timer_irq),
      .software_irq_i (software_irq),
      .external_irq_i (external_irq),
      .mstatus_mie_i  (mstatus_mie),
      .mie_i          (mie),
      .mtvec_i        (mtvec),
      .mepc_i         (mepc_in),
      .inst_valid_i   (inst_valid),
      .inst_pc_i      (inst_pc),
      .exc_valid_i    (exc_valid),
      .exc_cause_i    (exc_cause),
      .exc_tval_i     (exc_tval),
      .mret_i         (mret),
      .mip_o          (mip),
      .stall_o        (stall),
      .csr_we_o       (csr_we),
      .mepc_o         (mepc_out),
      .mcause_o       (mcause_out),
      .mtval_o        (mtval_out),
      .mret_o         (mret_out),
      .redirect_o     (redirect),
      .redirect_pc_o  (redirect_pc)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input int kind, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c);
      t_exp e;
      e.kind = kind; e.a = a; e.b = b; e.c = c;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every pulse must match the next queued expectation
   always @(negedge clk) begin
      if (csr_we || redirect || mret_out) begin
         int   kind;
         t_exp e;
         if (csr_we && !redirect && !mret_out)       kind = c_KIND_CSR;
         else if (redirect && !csr_we && !mret_out)  kind = c_KIND_JMP;
         else if (redirect && mret_out && !csr_we)   kind = c_KIND_MRET;
         else                                        kind = 3;
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse", 32'(kind), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("pulse_kind", 32'(kind), 32'(e.kind));
            if (e.kind == c_KIND_CSR) begin
               chk("mepc", mepc_out, e.a);
               chk("mcause", mcause_out, e.b);
               chk("mtval", mtval_out, e.c);
            end else begin
               chk("redirect_pc", redirect_pc, e.a);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      timer_irq = 0; software_irq = 0; external_irq = 0; mstatus_mie = 0;
      mie = 0; mtvec = 0; mepc_in = 0; inst_pc = 0; exc_tval = 0;
      inst_valid = 0; exc_valid = 0; mret = 0; exc_cause = 0;
      tick(); tick();
      #3;
      chk("rst_stall", {31'b0, stall}, 32'd0);
      chk("rst_csr_we", {31'b0, csr_we}, 32'd0);
      chk("rst_redirect", {31'b0, redirect}, 32'd0);
      chk("rst_mret", {31'b0, mret_out}, 32'd0);
      chk("rst_mip", mip, 32'd0);
      chk("rst_mcause", mcause_out, 32'd0);
      chk("rst_redirect_pc", redirect_pc, 32'd0);
      rst = 1'b0;
      tick();

      // Timer interrupt, direct mode
      mtvec = 32'h8000_0000; mie = 32'h80; mstatus_mie = 1;
      inst_valid = 1; inst_pc = 32'h100; timer_irq = 1;
      push(c_KIND_CSR, 32'h100, 32'h8000_0007, 32'h0);
      push(c_KIND_JMP, 32'h8000_0000, 0, 0);
      tick(); #3;
      chk("t1_mip", mip, 32'h80);
      chk("t1_stall_decide", {31'b0, stall}, 32'd1);
      tick(); mstatus_mie = 0; #3;
      chk("t1_stall_save", {31'b0, stall}, 32'd1);
      tick(); #3;
      chk("t1_stall_jump", {31'b0, stall}, 32'd1);
      tick(); #3;
      chk("t1_stall_idle", {31'b0, stall}, 32'd0);
      timer_irq = 0;
      tick();

      // All three IRQs, vectored mode: MEI wins
      mtvec = 32'h8000_0001; mie = 32'h888; mstatus_mie = 1; inst_pc = 32'h200;
      timer_irq = 1; software_irq = 1; external_irq = 1;
      push(c_KIND_CSR, 32'h200, 32'h8000_000B, 32'h0);
      push(c_KIND_JMP, 32'h8000_002C, 0, 0);
      tick(); #3;
      chk("t2_mip", mip, 32'h888);
      tick(); mstatus_mie = 0;
      tick(); tick(); #3;
      chk("t2_no_reentry_a", {31'b0, stall}, 32'd0);
      tick(); #3;
      chk("t2_no_reentry_b", {31'b0, stall}, 32'd0);
      timer_irq = 0; software_irq = 0; external_irq = 0;
      tick();

      // Exception with MTI pending: exception wins
      mtvec = 32'h8000_0000; mie = 32'h80; mstatus_mie = 1; inst_valid = 0;
      timer_irq = 1;
      tick(); #3;
      chk("t3_mip", mip, 32'h80);
      chk("t3_no_stall_invalid", {31'b0, stall}, 32'd0);
      inst_valid = 1; exc_valid = 1; exc_cause = 4'd2; exc_tval = 32'hDEAD;
      inst_pc = 32'h300;
      push(c_KIND_CSR, 32'h300, 32'h2, 32'hDEAD);
      push(c_KIND_JMP, 32'h8000_0000, 0, 0);
      #1;
      chk("t3_stall_decide", {31'b0, stall}, 32'd1);
      tick(); exc_valid = 0; mstatus_mie = 0;
      tick(); tick(); #3;
      chk("t3_stall_idle", {31'b0, stall}, 32'd0);
      timer_irq = 0;
      tick();

      // mret, nothing pending
      mstatus_mie = 1; mie = 32'h888; mepc_in = 32'h204; inst_pc = 32'h400; mret = 1;
      push(c_KIND_MRET, 32'h204, 0, 0);
      #1;
      chk("t4_stall_decide", {31'b0, stall}, 32'd1);
      tick(); mret = 0; #3;
      chk("t4_stall_mret", {31'b0, stall}, 32'd1);
      tick(); #3;
      chk("t4_stall_idle", {31'b0, stall}, 32'd0);

      // MSI pending but mie bit clear: no entry
      software_irq = 1; mie = 32'h8; inst_valid = 0;
      tick(); #3;
      chk("t5_mip", mip, 32'h8);
      mie = 32'h0; inst_valid = 1;
      #1;
      chk("t5_stall_masked", {31'b0, stall}, 32'd0);
      tick(); #3;
      chk("t5_csr_we_masked", {31'b0, csr_we}, 32'd0);
      // Enable it on an mret: interrupt beats mret
      mie = 32'h8; mret = 1; inst_pc = 32'h500;
      push(c_KIND_CSR, 32'h500, 32'h8000_0003, 32'h0);
      push(c_KIND_JMP, 32'h8000_0000, 0, 0);
      tick(); mret = 0; mstatus_mie = 0;
      tick(); tick(); #3;
      chk("t5_stall_idle", {31'b0, stall}, 32'd0);
      software_irq = 0;
      tick();

      // Reset during SAVE aborts the sequence
      timer_irq = 1; mie = 32'h80; mstatus_mie = 1; inst_pc = 32'h600;
      push(c_KIND_CSR, 32'h600, 32'h8000_0007, 32'h0);
      tick();
      tick(); rst = 1; timer_irq = 0;
      tick(); #3;
      chk("t6_stall", {31'b0, stall}, 32'd0);
      chk("t6_redirect", {31'b0, redirect}, 32'd0);
      chk("t6_mip", mip, 32'd0);
      chk("t6_mepc", mepc_out, 32'd0);
      chk("t6_mcause", mcause_out, 32'd0);
      chk("t6_redirect_pc", redirect_pc, 32'd0);
      rst = 0; mstatus_mie = 0;
      tick(); tick(); tick();

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
